// File: rtl/hack_alu_pipe.sv
// Two-stage pipelined Hack ALU: S1 conditions the operands, S2 computes the result and flags.
// Valid/ready handshake with full backpressure, pass-through tag and synchronous flush.
module hack_alu_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [5:0]       in_ctrl,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             zr,
    output logic             ng,
    output logic             cy,
    output logic             ov
);

    function automatic logic [WIDTH-1:0] cond_operand(input logic [WIDTH-1:0] d,
                                                      input logic zero, input logic neg);
        logic [WIDTH-1:0] v;
        v = zero ? {WIDTH{1'b0}} : d;
        return neg ? ~v : v;
    endfunction

    logic             s1_valid_r, s2_valid_r;
    logic             f_r, no_r;
    logic [WIDTH-1:0] x1_r, y1_r;
    logic [TAG_W-1:0] tag1_r, tag2_r;
    logic [WIDTH-1:0] out_data_r;
    logic             zr_r, ng_r, cy_r, ov_r;
    logic             s1_adv_s, s2_adv_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] z_s, res_s;
    logic             cy_s, ov_s;

    assign s2_adv_s  = !s2_valid_r || out_ready;
    assign s1_adv_s  = !s1_valid_r || s2_adv_s;
    assign in_ready  = s1_adv_s && !flush;
    assign out_valid = s2_valid_r;
    assign out_data  = out_data_r;
    assign out_tag   = tag2_r;
    assign zr        = zr_r;
    assign ng        = ng_r;
    assign cy        = cy_r;
    assign ov        = ov_r;

    // Stage 2 datapath: add/and, optional inversion; carry and overflow only exist for the add
    always_comb begin
        sum_s = {1'b0, x1_r} + {1'b0, y1_r};
        z_s   = x1_r & y1_r;
        cy_s  = 1'b0;
        ov_s  = 1'b0;
        if (f_r) begin
            z_s  = sum_s[WIDTH-1:0];
            cy_s = sum_s[WIDTH];
            ov_s = (x1_r[WIDTH-1] == y1_r[WIDTH-1]) && (sum_s[WIDTH-1] != x1_r[WIDTH-1]);
        end else begin
            z_s  = x1_r & y1_r;
        end
        if (no_r) begin
            res_s = ~z_s;
        end else begin
            res_s = z_s;
        end
    end

    // Stage 1 register: conditioned operands plus function select and tag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            x1_r       <= {WIDTH{1'b0}};
            y1_r       <= {WIDTH{1'b0}};
            f_r        <= 1'b0;
            no_r       <= 1'b0;
            tag1_r     <= {TAG_W{1'b0}};
        end else if (flush) begin
            s1_valid_r <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            x1_r       <= cond_operand(in_data0, in_ctrl[5], in_ctrl[4]);
            y1_r       <= cond_operand(in_data1, in_ctrl[3], in_ctrl[2]);
            f_r        <= in_ctrl[1];
            no_r       <= in_ctrl[0];
            tag1_r     <= in_tag;
        end
    end

    // Stage 2 register: holds the result steady while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            out_data_r <= {WIDTH{1'b0}};
            tag2_r     <= {TAG_W{1'b0}};
            zr_r       <= 1'b1;
            ng_r       <= 1'b0;
            cy_r       <= 1'b0;
            ov_r       <= 1'b0;
        end else if (flush) begin
            s2_valid_r <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            out_data_r <= res_s;
            tag2_r     <= tag1_r;
            zr_r       <= (res_s == {WIDTH{1'b0}});
            ng_r       <= res_s[WIDTH-1];
            cy_r       <= cy_s;
            ov_r       <= ov_s;
        end
    end

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Self-checking bench for hack_alu_pipe: directed test-plan cases plus randomized traffic
// scored against a transaction-level queue model of the ALU.
module tb_hack_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data0, in_data1, out_data;
    logic [5:0]  in_ctrl;
    logic [3:0]  in_tag, out_tag;
    logic        zr, ng, cy, ov;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  tag;
        logic        zr, ng, cy, ov;
        int          acc_edge;
    } exp_t;

    exp_t q[$];

    hack_alu_pipe #(.WIDTH(16), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data0(in_data0), .in_data1(in_data1), .in_ctrl(in_ctrl), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag),
        .zr(zr), .ng(ng), .cy(cy), .ov(ov)
    );

    always #5 clk = ~clk;

    // Reference: Hack semantics with integer arithmetic for the sum, carry and signed range
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [5:0] c, input logic [3:0] t);
        exp_t        e;
        logic [15:0] x, y, z;
        int unsigned u;
        int          s;
        x = c[5] ? 16'h0000 : a;
        if (c[4]) x = ~x;
        y = c[3] ? 16'h0000 : b;
        if (c[2]) y = ~y;
        if (c[1]) begin
            u    = int'(x) + int'(y);
            z    = u[15:0];
            e.cy = (u > 32'd65535);
            s    = int'($signed(x)) + int'($signed(y));
            e.ov = (s > 32767) || (s < -32768);
        end else begin
            z    = x & y;
            e.cy = 1'b0;
            e.ov = 1'b0;
        end
        if (c[0]) z = ~z;
        e.data     = z;
        e.zr       = (z == 16'h0000);
        e.ng       = z[15];
        e.tag      = t;
        e.acc_edge = 0;
        return e;
    endfunction

    // One clock: drive, check handshake and head-of-queue result, advance the model
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [5:0] c, input logic [3:0] t, input logic rdy,
                         input logic fl, output logic rdy_seen, output logic took,
                         output logic popped, output logic [3:0] tag_seen);
        logic exp_rdy, exp_val;
        exp_t e;
        in_valid = v; in_data0 = a; in_data1 = b; in_ctrl = c; in_tag = t;
        out_ready = rdy; flush = fl;
        @(negedge clk);
        exp_rdy = !fl && (q.size() < 2 || rdy);
        exp_val = (q.size() > 0) && (cyc >= q[0].acc_edge + 1);
        total++;
        if (in_ready !== exp_rdy) begin
            bad++;
            $display("FAIL in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_rdy);
        end
        total++;
        if (out_valid !== exp_val) begin
            bad++;
            $display("FAIL out_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_val);
        end
        if (exp_val && out_valid === 1'b1) begin
            total++;
            if ({out_data, out_tag, zr, ng, cy, ov} !==
                {q[0].data, q[0].tag, q[0].zr, q[0].ng, q[0].cy, q[0].ov}) begin
                bad++;
                $display("FAIL result cyc=%0d got data=%h tag=%h zr%b ng%b cy%b ov%b want data=%h tag=%h zr%b ng%b cy%b ov%b",
                         cyc, out_data, out_tag, zr, ng, cy, ov,
                         q[0].data, q[0].tag, q[0].zr, q[0].ng, q[0].cy, q[0].ov);
            end
        end
        rdy_seen = in_ready;
        took     = v && in_ready;
        popped   = out_valid && rdy;
        tag_seen = out_tag;
        e        = model(a, b, c, t);
        @(posedge clk);
        cyc++;
        if (popped && q.size() > 0) void'(q.pop_front());
        if (fl) begin
            q.delete();
        end else if (took) begin
            e.acc_edge = cyc;
            q.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        logic r, tk, p;
        logic [3:0] tg;
        cycle(1'b0, 16'h0000, 16'h0000, 6'b000000, 4'h0, rdy, 1'b0, r, tk, p, tg);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        cyc++;
        q.delete();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({out_valid, in_ready, out_data, out_tag, zr, ng, cy, ov} !==
            {1'b0, 1'b1, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got v%b r%b d=%h t=%h zr%b ng%b cy%b ov%b",
                     out_valid, in_ready, out_data, out_tag, zr, ng, cy, ov);
        end
    endtask

    // Single op with out_ready high: result visible two edges after acceptance
    task automatic test_op(input string name, input logic [5:0] c, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] wd,
                           input logic [3:0] wflags);
        logic r, tk, p;
        logic [3:0] tg;
        cycle(1'b1, a, b, c, 4'h5, 1'b1, 1'b0, r, tk, p, tg);
        idle(1'b1);
        total++;
        if ({out_valid, out_data, out_tag, zr, ng, cy, ov} !== {1'b1, wd, 4'h5, wflags}) begin
            bad++;
            $display("FAIL %s got v%b d=%h t=%h zr/ng/cy/ov=%b%b%b%b want v1 d=%h t=5 zr/ng/cy/ov=%b",
                     name, out_valid, out_data, out_tag, zr, ng, cy, ov, wd, wflags);
        end
        idle(1'b1);
    endtask

    task automatic test_backpressure();
        logic r, tk, p;
        logic [3:0] tg, next_tag;
        logic [15:0] held;
        logic [3:0] got[$];
        next_tag = 4'd1;
        held = 16'h0000;
        for (int c = 1; c <= 12; c++) begin
            cycle(next_tag <= 4'd4, 16'($urandom), 16'($urandom), 6'($urandom), next_tag,
                  !(c >= 2 && c <= 5), 1'b0, r, tk, p, tg);
            if (tk) next_tag = next_tag + 4'd1;
            if (p) got.push_back(tg);
            if (c == 3) begin
                held = out_data;
                total++;
                if (r !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_in_ready_full got=%b want=0", r);
                end
            end
            if (c == 4 || c == 5) begin
                total++;
                if (out_data !== held || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_stable got=%h/%b want=%h/1", out_data, out_valid, held);
                end
            end
        end
        total++;
        if (got.size() != 4 || got[0] !== 4'd1 || got[1] !== 4'd2 ||
            got[2] !== 4'd3 || got[3] !== 4'd4) begin
            bad++;
            $display("FAIL bp_order got n=%0d want tags 1,2,3,4", got.size());
        end
    endtask

    task automatic test_flush();
        logic r, tk, p;
        logic [3:0] tg;
        cycle(1'b1, 16'h0001, 16'h0002, 6'b000010, 4'h7, 1'b0, 1'b0, r, tk, p, tg);
        cycle(1'b1, 16'h0003, 16'h0004, 6'b000010, 4'h8, 1'b0, 1'b0, r, tk, p, tg);
        cycle(1'b1, 16'h0005, 16'h0006, 6'b000010, 4'h9, 1'b0, 1'b1, r, tk, p, tg);
        total++;
        if (out_valid !== 1'b0 || r !== 1'b0) begin
            bad++;
            $display("FAIL flush_clear got v=%b ready_in_flush=%b want 0/0", out_valid, r);
        end
        cycle(1'b1, 16'h0010, 16'h0020, 6'b000010, 4'hA, 1'b1, 1'b0, r, tk, p, tg);
        idle(1'b1);
        total++;
        if (out_valid !== 1'b1 || out_tag !== 4'hA || out_data !== 16'h0030) begin
            bad++;
            $display("FAIL flush_next got v%b t=%h d=%h want v1 t=a d=0030", out_valid, out_tag, out_data);
        end
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic test_reset_midstream();
        logic r, tk, p;
        logic [3:0] tg;
        cycle(1'b1, 16'h1234, 16'h4321, 6'b000010, 4'h3, 1'b0, 1'b0, r, tk, p, tg);
        cycle(1'b1, 16'h0F0F, 16'hF0F0, 6'b000000, 4'h4, 1'b0, 1'b0, r, tk, p, tg);
        cycle(1'b1, 16'hAAAA, 16'h5555, 6'b000011, 4'h6, 1'b0, 1'b0, r, tk, p, tg);
        do_reset();
        total++;
        if ({out_valid, in_ready, out_data, out_tag, zr, ng, cy, ov} !==
            {1'b0, 1'b1, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_midstream got v%b r%b d=%h t=%h zr%b ng%b cy%b ov%b",
                     out_valid, in_ready, out_data, out_tag, zr, ng, cy, ov);
        end
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic test_random();
        logic r, tk, p;
        logic [3:0] tg;
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 6'($urandom),
                  4'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
                  r, tk, p, tg);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL random_drain got=%0d left want=0", q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data0 = 16'h0000; in_data1 = 16'h0000; in_ctrl = 6'b000000; in_tag = 4'h0;
        test_reset();
        test_op("add_ovf",  6'b000010, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
        test_op("add_cy",   6'b000010, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
        test_op("x_minus_y", 6'b010011, 16'h0005, 16'h0005, 16'h0000, 4'b1000);
        test_op("const_m1", 6'b111010, 16'h1234, 16'h5678, 16'hFFFF, 4'b0100);
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hack_alu_pipe.md
# hack_alu_pipe

Parametrised, two-stage pipelined successor to the combinational Hack ALU. It keeps the same six-bit Hack control semantics (zx, nx, zy, ny, f, no) and generalises data width. It adds a valid/ready handshake with full backpressure, a pass-through tag, a flush, and carry/overflow flags. It sits between the decode stage and writeback of the pipelined Hack core and accepts one operation per clock.

## Interface

- WIDTH, 16, data width in bits (≥ 2)
- TAG_W, 4, width of the opaque tag carried alongside each operation (≥ 1)

Ports:

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low
- flush  in  1  synchronous discard of all in-flight operations
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept this cycle
- in_data0  in  WIDTH  x operand
- in_data1  in  WIDTH  y operand
- in_ctrl  in  6  {zx, nx, zy, ny, f, no}, bit 5 = zx
- in_tag  in  TAG_W  opaque tag, returned unchanged with the result
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result
- out_tag  out  TAG_W  tag of the result
- zr  out  1  out_data == 0
- ng  out  1  out_data[WIDTH-1]
- cy  out  1  carry out of the x1+y1 add
- ov  out  1  signed overflow of the x1+y1 add

## Operation

- Stage 1 (S1) register: holds x1, y1, f, no, tag and s1_valid.
  - x0 = zx ? 0 : in_data0; x1 = nx ? ~x0 : x0.
  - y0 and y1 are formed the same way from zy, ny and in_data1.
- Stage 2 (S2) register: holds out_data, zr, ng, cy, ov, tag and s2_valid; out_valid = s2_valid.
  - z = f ? (x1 + y1) mod 2^WIDTH : x1 & y1; out_data = no ? ~z : z.
  - The add uses WIDTH+1 bits; cy is bit WIDTH of that sum.
  - ov = (x1[MSB] == y1[MSB]) && (sum[MSB] != x1[MSB]).
  - When f=0: cy=0 and ov=0.
  - zr and ng are computed from the final out_data, after the no inversion. cy and ov are not affected by no.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is a combinational path from out_ready, which is permitted.
- S2 loads from S1 when s2_adv. The new s2_valid = s1_valid.
- S1 loads from the inputs when s1_adv. The new s1_valid = in_valid.
- Data registers may load when the corresponding valid is 0; outputs are don't-care while out_valid=0, except the flags (see reset).
- Ordering: results leave in acceptance order. No operation is dropped or duplicated except by flush or reset.
- Flush (rst_n=1, flush=1):
  - s1_valid and s2_valid clear on that edge.
  - in_ready is forced to 0 that cycle, so the offered input is not accepted.
  - A result presented that cycle with out_ready=1 still counts as consumed.
- Reset dominates flush.

## Timing

- Reset (rst_n=0 at an edge): s1_valid=0, s2_valid=0, out_data=0, out_tag=0, zr=1, ng=0, cy=0, ov=0. in_ready reads 1 in the first cycle after reset is released. Reset mid-operation discards both stages with no partial result.
- Latency: an input accepted at edge N has out_valid=1 from edge N+2, provided out_ready was high at edge N+1 or S2 was empty.
- Throughput: 1 op/clock while out_ready=1.
- Stall: with out_ready=0 and out_valid=1, S2 holds. S1 holds if full. in_ready=0 when both stages are full.
- Maximum occupancy is 2. When out_ready rises, one result drains per cycle and in_ready returns to 1 in the same cycle.
- Simultaneous drain and fill: with S2 full, out_ready=1, S1 full and in_valid=1, all three transfers occur on the same edge.
- out_data, out_tag and the flags are stable while out_valid=1 and out_ready=0.

## Test plan

All cases use WIDTH=16.

- Add with signed overflow: ctrl 000010, x=0x7FFF, y=0x0001 → after 2 cycles out_data=0x8000, ng=1, ov=1, cy=0, zr=0.
- Add with carry: ctrl 000010, x=0xFFFF, y=0x0001 → out_data=0x0000, zr=1, cy=1, ov=0, ng=0.
- x−y: ctrl 010011, x=5, y=5 → out_data=0, zr=1, cy=0, ov=0. Then constant −1 (ctrl 111010) → 0xFFFF, ng=1, zr=0, cy=0.
- Backpressure:
  - Stimulus: offer tags 1..4 back-to-back, with out_ready=0 for cycles 2–5.
  - Required: in_ready drops after 2 ops are held; out_data and flags stay stable while stalled; tags emerge 1, 2, 3, 4 with no loss.
- Flush and reset mid-stream:
  - Flush with both stages full → out_valid=0 next cycle, the input offered in the flush cycle is not accepted, and the next accepted op emerges with correct latency.
  - rst_n=0 mid-stream → all outputs at reset values and in_ready=1 in the first cycle after reset is released.
